// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the chunked sequential adder/subtractor.
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk counter width; never zero even when a single chunk covers the word.
    function automatic int cnt_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/seq_addsub_n_chunk_adder.sv
// Combinational CHUNK-bit ripple adder, time-shared by seq_addsub_n across chunks.
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            assign sum[gi]  = x[gi] ^ y[gi] ^ c[gi];
            assign c[gi+1]  = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign cout  = c[CHUNK];
    // Carry into the top bit; paired with cout to detect signed overflow.
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub_n.sv
// Multi-cycle adder/subtractor: one operand pair per transaction, CHUNK bits per clock, LSB first.
module seq_addsub_n
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             of,
    output logic             busy
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = cnt_width(NCH);
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_addsub_n: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    state_t            state_reg;
    logic [KW-1:0]     k_reg;
    logic              carry_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [CHUNK-1:0]  s_chunk_reg [NCH];
    logic              co_reg;
    logic              of_reg;

    logic [CHUNK-1:0]  a_chunk [NCH];
    logic [CHUNK-1:0]  b_chunk [NCH];
    logic [CHUNK-1:0]  sum_w;
    logic              cout_w;
    logic              c_msb_w;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
            assign a_chunk[gi]             = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi]             = b_reg[gi*CHUNK +: CHUNK];
            assign s[gi*CHUNK +: CHUNK]    = s_chunk_reg[gi];
        end
    endgenerate

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x     (a_chunk[k_reg]),
        .y     (b_chunk[k_reg]),
        .cin   (carry_reg),
        .sum   (sum_w),
        .cout  (cout_w),
        .c_msb (c_msb_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            co_reg    <= 1'b0;
            of_reg    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                s_chunk_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction folds into addition: a + ~b + ~borrow.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ^ ci;
                        k_reg     <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    s_chunk_reg[k_reg] <= sum_w;
                    carry_reg          <= cout_w;
                    if (k_reg == K_LAST) begin
                        co_reg    <= cout_w;
                        of_reg    <= cout_w ^ c_msb_w;
                        k_reg     <= '0;
                        state_reg <= DONE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN) || (state_reg == DONE);
    assign co        = co_reg;
    assign of        = of_reg;

endmodule
